twiddle_w8_mul: RTL

- Pipelined complex multiplier by the 8-point FFT twiddle factors W8^k = exp(-j·pi·k/4), k = 0..3.
- Sits between butterfly stages of the 8-point FFT datapath.
- Multiplies by 1/sqrt(2) (constant 181/256) using shift-adds only, with rounding and saturation.
- Uses a valid/ready stream interface with full back-pressure, so the FFT pipeline can stall.

---
 rtl/twiddle_pkg.sv | 16 +
 rtl/twiddle_w8_mul_scale.sv | 50 +++++
 rtl/twiddle_w8_mul.sv | 63 ++++++
 3 files changed

// File: rtl/twiddle_pkg.sv
// twiddle_pkg: constants, twiddle index encoding and saturation limits for twiddle_w8_mul
package twiddle_pkg;
   localparam int INV_SQRT2_NUM = 181;
   localparam int INV_SQRT2_SHIFT = 8;
   localparam int ROUND_CONST = 128;
   localparam int N_SHIFTS = 5;
   // 181 = 2^7 + 2^5 + 2^4 + 2^2 + 2^0
   localparam int SHIFTS [N_SHIFTS] = '{7, 5, 4, 2, 0};
   typedef enum logic [1:0] {K_W0 = 2'd0, K_W1 = 2'd1, K_W2 = 2'd2, K_W3 = 2'd3} twiddle_k_t;
   function automatic longint sat_hi(input int w);
      return (longint'(1) <<< (w - 1)) - 1;
   endfunction
   function automatic longint sat_lo(input int w);
      return -(longint'(1) <<< (w - 1));
   endfunction
endpackage

// File: rtl/twiddle_w8_mul_scale.sv
// scale_inv_sqrt2: one component's x181 shift-add, round-half-up >>8 and saturation (stages 2-3)
// ports: clk, rst, en (shared pipeline enable), s/scale (stage-1 component), y/sat (stage-3 result)
module scale_inv_sqrt2
   import twiddle_pkg::*;
#(
   parameter int W = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic signed [W+1:0] s,
   input  logic                scale,
   output logic signed [W-1:0] y,
   output logic                sat
);
   localparam int P = W + 10;
   localparam int R = P - INV_SQRT2_SHIFT;
   logic signed [P-1:0] sx, p0_d, p1_d, p0, p1, sum;
   logic signed [P-1:0] t [N_SHIFTS];
   logic signed [R-1:0] r;
   logic signed [W-1:0] y_d;
   logic hi, lo;
   assign sx = P'(s);
   for (genvar i = 0; i < N_SHIFTS; i++) begin : g_t
      assign t[i] = sx <<< SHIFTS[i];
   end
   // unscaled samples are pre-shifted by 8 so the round/shift stage is uniform
   always_comb begin
      p0_d = scale ? t[0] + t[1] + t[2] : sx <<< INV_SQRT2_SHIFT;
      p1_d = scale ? t[3] + t[4] : '0;
      sum = p0 + p1 + P'(ROUND_CONST);
      r = R'(sum >>> INV_SQRT2_SHIFT);
      hi = r > sat_hi(W);
      lo = r < sat_lo(W);
      y_d = hi ? W'(sat_hi(W)) : lo ? W'(sat_lo(W)) : r[W-1:0];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         p0 <= '0;
         p1 <= '0;
         y <= '0;
         sat <= 1'b0;
      end else if (en) begin
         p0 <= p0_d;
         p1 <= p1_d;
         y <= y_d;
         sat <= hi | lo;
      end
   end
endmodule

// File: rtl/twiddle_w8_mul.sv
// twiddle_w8_mul: 3-stage valid/ready complex multiplier by W8^k, k=0..3, rounded and saturated
// ports: clk, rst; in_valid/in_ready/in_re/in_im/in_k/in_tag; out_valid/out_ready/out_re/out_im/out_tag/out_sat
module twiddle_w8_mul
   import twiddle_pkg::*;
#(
   parameter int N = 4,
   parameter int TAG_W = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic signed [2**N-1:0] in_re,
   input  logic signed [2**N-1:0] in_im,
   input  logic [1:0]             in_k,
   input  logic [TAG_W-1:0]       in_tag,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic signed [2**N-1:0] out_re,
   output logic signed [2**N-1:0] out_im,
   output logic [TAG_W-1:0]       out_tag,
   output logic                   out_sat
);
   localparam int W = 2 ** N;
   logic en, v1, v2, v3, sc1, sat_re, sat_im;
   logic signed [W+1:0] a, b, pr_d, pi_d, pr1, pi1;
   logic [TAG_W-1:0] t1, t2, t3;
   twiddle_k_t k;
   assign en = out_ready | ~v3;
   assign in_ready = en;
   assign out_valid = v3;
   assign out_tag = t3;
   assign out_sat = sat_re | sat_im;
   assign k = twiddle_k_t'(in_k);
   always_comb begin
      a = (W+2)'(in_re);
      b = (W+2)'(in_im);
      pr_d = k == K_W0 ? a : k == K_W1 ? a + b : k == K_W2 ? b : b - a;
      pi_d = k == K_W0 ? b : k == K_W1 ? b - a : k == K_W2 ? -a : -(a + b);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         {v1, v2, v3} <= '0;
         {pr1, pi1, sc1} <= '0;
         {t1, t2, t3} <= '0;
      end else if (en) begin
         {v1, v2, v3} <= {in_valid, v1, v2};
         {t2, t3} <= {t1, t2};
         if (in_valid) begin
            pr1 <= pr_d;
            pi1 <= pi_d;
            sc1 <= in_k[0];
            t1 <= in_tag;
         end
      end
   end
   scale_inv_sqrt2 #(.W(W)) u_re (
      .clk(clk), .rst(rst), .en(en), .s(pr1), .scale(sc1), .y(out_re), .sat(sat_re)
   );
   scale_inv_sqrt2 #(.W(W)) u_im (
      .clk(clk), .rst(rst), .en(en), .s(pi1), .scale(sc1), .y(out_im), .sat(sat_im)
   );
endmodule
